// File: rtl/imem_param_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_param_ctrl : parametrised instruction memory with program-load     |
// |   port, registered fetch port (valid/fault) and power-up NOP clear.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imem_param_ctrl #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 128,
   parameter int                ADDR_W    = 32,
   parameter int                BYTE_ADDR = 0,
   parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
   input  logic              clk_i,
   input  logic              rsta_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              rd_fault_o,
   output logic              busy_o
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                CMP_W    = ((ADDR_W > 32) ? ADDR_W : 32) + 1;
   localparam logic [CMP_W-1:0]  DEPTH_C  = CMP_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Range test is done on the full-width index so large addresses never alias.
   function automatic logic [ADDR_W-1:0] f_index(input logic [ADDR_W-1:0] a);
      if (BYTE_ADDR != 0) return a >> 2;
      else                return a;
   endfunction

   function automatic logic f_legal(input logic [ADDR_W-1:0] a);
      logic misaligned;
      misaligned = (BYTE_ADDR != 0) && (a[1:0] != 2'b00);
      return !misaligned && (CMP_W'(f_index(a)) < DEPTH_C);
   endfunction

   function automatic logic [IDX_W-1:0] f_slot(input logic [ADDR_W-1:0] a);
      return IDX_W'(f_index(a));
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   state_t            state_q;
   logic [IDX_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              rd_fault_q;
   logic              busy_q;

   logic              rd_ok;
   logic              wr_ok;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;

   assign rd_ok  = f_legal(rd_addr_i);
   assign wr_ok  = f_legal(wr_addr_i);
   assign rd_idx = f_slot(rd_addr_i);
   assign wr_idx = f_slot(wr_addr_i);

   // Storage has no reset of its own; the clear sequencer initialises it.
   always_ff @(posedge clk_i) begin
      if (!rsta_i) begin
         if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= NOP_WORD;
         end else if (wr_en_i && wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rsta_i) begin
         state_q    <= ST_CLEAR;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_fault_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               rd_valid_q <= 1'b0;
               rd_fault_q <= 1'b0;
               cnt_q      <= cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            ST_READY: begin
               // Array read sees pre-edge contents, giving read-first on collisions.
               rd_valid_q <= rd_req_i;
               rd_fault_q <= rd_req_i && !rd_ok;
               if (rd_req_i) begin
                  rd_data_q <= rd_ok ? mem_q[rd_idx] : NOP_WORD;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_fault_o = rd_fault_q;
   assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_param_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_param_ctrl : bench for imem_param_ctrl (word and byte modes).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imem_param_ctrl;

   typedef struct packed {
      logic [31:0] d;
      logic        f;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rsta, a_wr_en, a_rd_req;
   logic [31:0] a_wr_addr, a_wr_data, a_rd_addr;
   logic [31:0] a_rd_data;
   logic        a_rd_valid, a_rd_fault, a_busy;

   logic        b_rsta, b_wr_en, b_rd_req;
   logic [31:0] b_wr_addr, b_wr_data, b_rd_addr;
   logic [31:0] b_rd_data;
   logic        b_rd_valid, b_rd_fault, b_busy;

   int          total = 0;
   int          bad   = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   imem_param_ctrl #(
      .DATA_W(32), .DEPTH(128), .ADDR_W(32), .BYTE_ADDR(0), .NOP_WORD(32'h0)
   ) u_a (
      .clk_i(clk), .rsta_i(a_rsta),
      .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
      .rd_req_i(a_rd_req), .rd_addr_i(a_rd_addr),
      .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .rd_fault_o(a_rd_fault),
      .busy_o(a_busy)
   );

   imem_param_ctrl #(
      .DATA_W(32), .DEPTH(16), .ADDR_W(32), .BYTE_ADDR(1), .NOP_WORD(32'h0000_0013)
   ) u_b (
      .clk_i(clk), .rsta_i(b_rsta),
      .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
      .rd_req_i(b_rd_req), .rd_addr_i(b_rd_addr),
      .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .rd_fault_o(b_rd_fault),
      .busy_o(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, score both outputs against the queues, drop strobes.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      chk("a_valid", {31'b0, a_rd_valid}, {31'b0, qa.size() != 0});
      if (qa.size() != 0) begin
         e = qa.pop_front();
         chk("a_data",  a_rd_data, e.d);
         chk("a_fault", {31'b0, a_rd_fault}, {31'b0, e.f});
      end
      chk("b_valid", {31'b0, b_rd_valid}, {31'b0, qb.size() != 0});
      if (qb.size() != 0) begin
         e = qb.pop_front();
         chk("b_data",  b_rd_data, e.d);
         chk("b_fault", {31'b0, b_rd_fault}, {31'b0, e.f});
      end
      a_rd_req = 1'b0;
      a_wr_en  = 1'b0;
      b_rd_req = 1'b0;
      b_wr_en  = 1'b0;
   endtask

   task automatic rd_a(input logic [31:0] addr, input logic [31:0] d, input logic f);
      exp_t e;
      a_rd_req  = 1'b1;
      a_rd_addr = addr;
      e.d = d;
      e.f = f;
      qa.push_back(e);
   endtask

   task automatic rd_b(input logic [31:0] addr, input logic [31:0] d, input logic f);
      exp_t e;
      b_rd_req  = 1'b1;
      b_rd_addr = addr;
      e.d = d;
      e.f = f;
      qb.push_back(e);
   endtask

   task automatic wr_a(input logic [31:0] addr, input logic [31:0] data);
      a_wr_en   = 1'b1;
      a_wr_addr = addr;
      a_wr_data = data;
   endtask

   task automatic wr_b(input logic [31:0] addr, input logic [31:0] data);
      b_wr_en   = 1'b1;
      b_wr_addr = addr;
      b_wr_data = data;
   endtask

   initial begin
      int n;
      a_rsta = 1'b1; a_wr_en = 1'b0; a_rd_req = 1'b0;
      a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
      b_rsta = 1'b1; b_wr_en = 1'b0; b_rd_req = 1'b0;
      b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
      tick();
      tick();
      chk("a_rst_data",  a_rd_data, 32'h0);
      chk("a_rst_fault", {31'b0, a_rd_fault}, 32'h0);
      chk("a_rst_busy",  {31'b0, a_busy}, 32'h1);

      // Clear sequence: fetches during CLEAR must be ignored.
      a_rsta = 1'b0;
      n = 0;
      while (a_busy && n < 300) begin
         a_rd_req  = 1'b1;
         a_rd_addr = n;
         tick();
         n++;
      end
      chk("a_busy_len", n, 32'd128);

      rd_a(0, 32'h0, 1'b0);   tick();
      rd_a(64, 32'h0, 1'b0);  tick();
      rd_a(127, 32'h0, 1'b0); tick();

      wr_a(0, 32'h0635_0000); tick();
      wr_a(1, 32'h4620_0000); tick();
      rd_a(0, 32'h0635_0000, 1'b0); tick();
      rd_a(1, 32'h4620_0000, 1'b0); tick();

      // Same-address read/write collision is read-first.
      wr_a(5, 32'hDEAD_BEEF); rd_a(5, 32'h0, 1'b0); tick();
      rd_a(5, 32'hDEAD_BEEF, 1'b0); tick();

      // Out-of-range fetch and dropped writes that would alias if truncated.
      rd_a(128, 32'h0, 1'b1); wr_a(200, 32'hA5A5_A5A5); tick();
      rd_a(72, 32'h0, 1'b0);  wr_a(133, 32'h1234_5678); tick();
      rd_a(5, 32'hDEAD_BEEF, 1'b0); wr_a(32'h8000_0000, 32'hFFFF_FFFF); tick();
      rd_a(32'hFFFF_FFFF, 32'h0, 1'b1); tick();
      rd_a(0, 32'h0635_0000, 1'b0); tick();
      tick();
      chk("a_hold_data", a_rd_data, 32'h0635_0000);

      // Reset in READY with a fetch in flight, then reset again mid-clear.
      a_rsta = 1'b1; a_rd_req = 1'b1; a_rd_addr = 0;
      tick();
      chk("a_rst2_data", a_rd_data, 32'h0);
      chk("a_rst2_busy", {31'b0, a_busy}, 32'h1);
      a_rsta = 1'b0;
      for (int i = 0; i < 50; i++) begin
         a_rd_req = 1'b1;
         tick();
      end
      chk("a_mid_busy", {31'b0, a_busy}, 32'h1);
      a_rsta = 1'b1;
      tick();
      a_rsta = 1'b0;
      n = 0;
      while (a_busy && n < 300) begin
         a_rd_req  = 1'b1;
         a_rd_addr = 1;
         tick();
         n++;
      end
      chk("a_busy_len2", n, 32'd128);
      for (int i = 0; i < 128; i++) begin
         rd_a(i, 32'h0, 1'b0);
         tick();
      end

      // Byte-addressed instance with a non-zero NOP pattern.
      b_rsta = 1'b0;
      n = 0;
      while (b_busy && n < 100) begin
         tick();
         n++;
      end
      chk("b_busy_len", n, 32'd16);
      wr_b(32'h8, 32'hCAFE_0001); tick();
      wr_b(32'h4, 32'h1111_1111); tick();
      rd_b(32'h8, 32'hCAFE_0001, 1'b0); tick();
      rd_b(32'h9, 32'h0000_0013, 1'b1); tick();
      rd_b(32'h4, 32'h1111_1111, 1'b0); wr_b(32'hA, 32'h0000_0BAD); tick();
      rd_b(32'h8, 32'hCAFE_0001, 1'b0); tick();
      rd_b(32'h40, 32'h0000_0013, 1'b1); wr_b(32'h48, 32'h7777_7777); tick();
      rd_b(32'h3C, 32'h0000_0013, 1'b0); tick();
      rd_b(32'h8, 32'hCAFE_0001, 1'b0); tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_param_ctrl.md
Name: imem_param_ctrl

Overview:
- Parametrised instruction memory for the single-cycle/multicycle CPU datapath.
- Generalises width and depth and adds a runtime program-load write port.
- Adds a registered read port with valid and fault flags, and an optional byte-addressed mode.
- After reset, a clear sequencer fills every word with a NOP pattern, one word per cycle, before any access is accepted.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 128, number of words; any value ≥ 2.
- ADDR_W, 32, width of the read and write address ports.
- BYTE_ADDR, 0, 0 = word addressing (index = addr); 1 = byte addressing (index = addr >> 2, addr[1:0] must be 0).
- NOP_WORD, 0, fill pattern written during clear and returned on faulted reads.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rsta, input, 1, synchronous active-high reset.
- wr_en, input, 1, program-load write strobe.
- wr_addr, input, ADDR_W, program-load address.
- wr_data, input, DATA_W, program-load data.
- rd_req, input, 1, fetch request.
- rd_addr, input, ADDR_W, fetch address (PC).
- rd_data, output, DATA_W, registered fetch data.
- rd_valid, output, 1, rd_data is valid this cycle.
- rd_fault, output, 1, qualifies rd_valid: out-of-range or misaligned fetch.
- busy, output, 1, clear sequence in progress.

Behaviour:
- Reset (rsta = 1 at a rising edge):
  - FSM enters CLEAR and the clear counter goes to 0.
  - rd_data = 0, rd_valid = 0, rd_fault = 0, busy = 1.
  - Reset asserted mid-CLEAR restarts the counter at 0.
  - Reset asserted in READY discards any in-flight read; rd_valid = 0 on the next cycle.
- CLEAR state:
  - Each cycle, mem[cnt] <= NOP_WORD and cnt increments.
  - On the cycle that writes index DEPTH-1, the next state is READY and busy drops to 0.
  - The first READY cycle occurs exactly DEPTH cycles after rsta deasserts.
  - rd_req and wr_en are ignored; rd_valid stays 0.
- READY state:
  - Stays in READY until the next reset.
- Index computation:
  - idx = addr when BYTE_ADDR = 0; idx = addr >> 2 when BYTE_ADDR = 1.
  - Out of range when idx ≥ DEPTH.
  - Misaligned when BYTE_ADDR = 1 and addr[1:0] ≠ 0.
  - All comparisons are made at full ADDR_W width; there is no truncation or wrap-around.
- Writes:
  - wr_en with an in-range, aligned address writes mem[idx] at the edge.
  - Invalid addresses are dropped silently; memory is unchanged.
- Reads:
  - Latency is 1 cycle. rd_req sampled at edge t gives rd_valid = 1 after edge t, with rd_data = mem[idx].
  - One request per cycle; back-to-back requests give a continuous rd_valid stream.
  - With no rd_req, rd_valid = 0 next cycle; rd_data holds its last value.
  - Faulted read: rd_valid = 1, rd_fault = 1, rd_data = NOP_WORD.
  - Valid read: rd_fault = 0.
- Read and write in the same cycle:
  - Same address: read-first; rd_data returns the old contents and the new value is visible from the next read.
  - Different addresses: both complete independently.

Test Plan:
- Reset then idle, DEPTH = 128 → busy = 1 for 128 cycles, then 0; reads of idx 0, 64, 127 return 0x00000000 with rd_fault = 0.
- Write 0x06350000 to idx 0 and 0x46200000 to idx 1, then rd_req at 0 and 1 back-to-back → rd_valid high for 2 consecutive cycles, data 0x06350000 then 0x46200000.
- Same-cycle wr_en and rd_req to idx 5 (old 0x0, new 0xDEADBEEF) → read returns 0x0; next read of idx 5 returns 0xDEADBEEF.
- rd_addr = 128 with DEPTH = 128, and a write to 200 → rd_valid = 1, rd_fault = 1, rd_data = NOP_WORD; memory is unchanged.
- BYTE_ADDR = 1: read addr 0x8 → returns mem[2] with rd_fault = 0; read addr 0x9 → rd_fault = 1.
- rsta pulsed at clear cycle 50 after memory was loaded → clear restarts; busy stays high 128 more cycles; afterwards all words read NOP_WORD; rd_req during CLEAR produces no rd_valid.
